systolic_seq_ctrl: RTL and testbench
====================================

# systolic_seq_ctrl

Sequencer for the HEIGHT x WIDTH output-stationary systolic array. On a start request it fetches operands from the external A/B matrix memories into the array edge buffers. It then issues the skewed per-row and per-column valid pattern for K_SIZE MAC steps, waits for the wavefront to drain, and pulses `done`. It replaces the hand-driven `start_compute`/`in_valid_A`/`in_valid_B` stimulus currently supplied around the array top.

## Interface
- `WIDTH`, 4: array columns (N dimension).
- `HEIGHT`, 4: array rows (M dimension).
- `K_SIZE`, 16: inner dimension; MAC steps per PE.
- `PE_LAT`, 1: PE multiply-accumulate pipeline latency in cycles (>=1).
- `ADDR_W`, 7: read address width; must hold K_SIZE*max(HEIGHT,WIDTH)-1.
- `CNT_W`, 8: compute step counter width; must hold T_END (defined below).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `data_valid` in 1: start request; sampled only in IDLE.
- `read_data` out 1: memory read strobe; equals `rd_en_A | rd_en_B`.
- `rd_en_A` out 1: A memory read enable.
- `rd_en_B` out 1: B memory read enable.
- `rd_addr` out ADDR_W: shared element address for A and B.
- `clr_acc` out 1: one-cycle accumulator clear to all PEs.
- `start_compute` out 1: one-cycle pulse marking compute step t=0.
- `in_valid_A` out HEIGHT: per-row operand valid into the left edge.
- `in_valid_B` out WIDTH: per-column operand valid into the top edge.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, LOAD_WAIT, COMPUTE, DONE.
- IDLE: all outputs 0. `data_valid`=1 at a rising edge moves the FSM to LOAD.
- LOAD lasts L = K_SIZE*max(HEIGHT,WIDTH) cycles, with local index `rd_addr` = 0..L-1 incrementing by 1 per cycle.
  - `rd_en_A` = (rd_addr < K_SIZE*HEIGHT).
  - `rd_en_B` = (rd_addr < K_SIZE*WIDTH).
  - `clr_acc` = 1 in the first LOAD cycle only.
- Memory returns data one cycle after the strobe. LOAD_WAIT is a single cycle that absorbs the last return, with all read outputs low.
- COMPUTE: step counter t = 0..T_END-1, where T_END = K_SIZE + HEIGHT + WIDTH - 2 + PE_LAT.
  - `start_compute` = (t==0).
  - `in_valid_A[h]` = (h <= t < h+K_SIZE).
  - `in_valid_B[w]` = (w <= t < w+K_SIZE).
- DONE: `done`=1 for exactly one cycle, then IDLE. PE results are not touched and remain valid until the next `clr_acc`.
- `data_valid` in any state other than IDLE is ignored; it is not queued. `data_valid` still high in the first IDLE cycle after DONE starts a new run.
- All outputs are registered and glitch-free. `rd_addr` holds 0 outside LOAD.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE and all counters reset to 0.
- Asserting `rst_n` low mid-operation forces IDLE and zero outputs immediately (asynchronous). No `done` is produced for the aborted run.
- With E0 as the edge that accepts `data_valid`:
  - LOAD occupies edges E0..E(L-1).
  - LOAD_WAIT follows edge E(L).
  - COMPUTE t=0 follows edge E(L+1).
  - DONE follows edge E(L+1+T_END).
- Defaults: L=64, T_END=23, so `done` is high after edge E88 and `busy` stays high for 89 cycles.
- Start-to-done latency is exactly L+1+T_END+1 cycles of `busy`, with no data-dependent variation.
- Boundaries:
  - HEIGHT != WIDTH: the shorter enable drops early while `rd_addr` continues to L-1.
  - K_SIZE=1: each valid is a single-cycle pulse.
  - Counters never wrap within a run. The CNT_W and ADDR_W sizing rules are mandatory.

## Test plan
- Default parameters, one `data_valid` pulse:
  - `read_data` is high for 64 cycles with `rd_addr` 0..63.
  - `clr_acc` coincides with `rd_addr`=0.
  - `start_compute` is high 65 edges after E0.
  - `in_valid_A[3]` is high for t=3..18.
  - `done` is high 88 edges after E0.
  - PE results match the golden 4x4 matrix.
- `data_valid` pulsed at t=5 of COMPUTE and again during DONE: both are ignored. `done` asserts once and the FSM returns to IDLE.
- `data_valid` held high continuously: back-to-back runs, with a second `clr_acc` exactly 1 IDLE cycle after each `done`. Results are correct for both runs with different matrices.
- HEIGHT=2, WIDTH=4, K_SIZE=3:
  - L=12, `rd_en_A` is high for addresses 0..5 and `rd_en_B` for 0..11.
  - T_END=8.
  - `done` is high 21 edges after E0.
- `rst_n` dropped at COMPUTE t=10: all outputs are 0 within the same cycle and no `done` appears. A fresh run afterwards completes with the correct result.
- PE_LAT=3 with defaults: T_END=25 and `done` is high 90 edges after E0. Valid patterns are unchanged from the PE_LAT=1 case.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - operand fetch and skewed valid sequencer for the output-stationary systolic array
// All outputs are registered copies of values decoded from the next state, so they change only on clk.
module systolic_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4,
  parameter int K_SIZE = 16,
  parameter int PE_LAT = 1,
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_valid,
  output logic              read_data,
  output logic              rd_en_A,
  output logic              rd_en_B,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              clr_acc,
  output logic              start_compute,
  output logic [HEIGHT-1:0] in_valid_A,
  output logic [WIDTH-1:0]  in_valid_B,
  output logic              busy,
  output logic              done
);

  localparam int MAX_D = (HEIGHT > WIDTH) ? HEIGHT : WIDTH;
  localparam int L_LEN = K_SIZE * MAX_D;
  localparam int A_LEN = K_SIZE * HEIGHT;
  localparam int B_LEN = K_SIZE * WIDTH;
  localparam int T_END = K_SIZE + HEIGHT + WIDTH - 2 + PE_LAT;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(L_LEN - 1);
  localparam logic [CNT_W-1:0]  T_LAST    = CNT_W'(T_END - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_WAIT,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    t_q, t_d;
  logic                read_data_q, read_data_d;
  logic                rd_en_a_q, rd_en_a_d;
  logic                rd_en_b_q, rd_en_b_d;
  logic                clr_acc_q, clr_acc_d;
  logic                start_compute_q, start_compute_d;
  logic [HEIGHT-1:0]   in_valid_a_q, in_valid_a_d;
  logic [WIDTH-1:0]    in_valid_b_q, in_valid_b_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d = state_q;
    addr_d  = '0;
    t_d     = '0;
    unique case (state_q)
      S_IDLE:      if (data_valid) state_d = S_LOAD;
      S_LOAD: begin
        if (addr_q == ADDR_LAST) state_d = S_LOAD_WAIT;
        else                     addr_d  = addr_q + ADDR_W'(1);
      end
      S_LOAD_WAIT: state_d = S_COMPUTE;
      S_COMPUTE: begin
        if (t_q == T_LAST) state_d = S_DONE;
        else               t_d     = t_q + CNT_W'(1);
      end
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Decode from the upcoming state and counters so the registered outputs line up with that state.
  always_comb begin
    rd_en_a_d       = (state_d == S_LOAD) && (int'(addr_d) < A_LEN);
    rd_en_b_d       = (state_d == S_LOAD) && (int'(addr_d) < B_LEN);
    read_data_d     = rd_en_a_d | rd_en_b_d;
    clr_acc_d       = (state_d == S_LOAD) && (state_q == S_IDLE);
    start_compute_d = (state_d == S_COMPUTE) && (t_d == '0);
    busy_d          = (state_d != S_IDLE);
    done_d          = (state_d == S_DONE);
    in_valid_a_d    = '0;
    in_valid_b_d    = '0;
    for (int h = 0; h < HEIGHT; h++) begin
      in_valid_a_d[h] = (state_d == S_COMPUTE) && (int'(t_d) >= h) && (int'(t_d) < h + K_SIZE);
    end
    for (int w = 0; w < WIDTH; w++) begin
      in_valid_b_d[w] = (state_d == S_COMPUTE) && (int'(t_d) >= w) && (int'(t_d) < w + K_SIZE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      t_q             <= '0;
      read_data_q     <= 1'b0;
      rd_en_a_q       <= 1'b0;
      rd_en_b_q       <= 1'b0;
      clr_acc_q       <= 1'b0;
      start_compute_q <= 1'b0;
      in_valid_a_q    <= '0;
      in_valid_b_q    <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      t_q             <= t_d;
      read_data_q     <= read_data_d;
      rd_en_a_q       <= rd_en_a_d;
      rd_en_b_q       <= rd_en_b_d;
      clr_acc_q       <= clr_acc_d;
      start_compute_q <= start_compute_d;
      in_valid_a_q    <= in_valid_a_d;
      in_valid_b_q    <= in_valid_b_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign read_data     = read_data_q;
  assign rd_en_A       = rd_en_a_q;
  assign rd_en_B       = rd_en_b_q;
  assign rd_addr       = addr_q;
  assign clr_acc       = clr_acc_q;
  assign start_compute = start_compute_q;
  assign in_valid_A    = in_valid_a_q;
  assign in_valid_B    = in_valid_b_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - scoreboard bench for three sequencer configurations plus a behavioural 4x4 array
// Expected output traces come from a cycle-offset model; instance 0 also drives a behavioural array checked against a plain matmul.
module tb_systolic_seq_ctrl;

  localparam int PH[3] = '{4, 2, 4};
  localparam int PW[3] = '{4, 4, 4};
  localparam int PK[3] = '{16, 3, 16};
  localparam int PP[3] = '{1, 1, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data_valid = 1'b0;
  always #5 clk = ~clk;

  logic       rd0, ra0, rb0, cl0, st0, bz0, dn0;
  logic [6:0] ad0;
  logic [3:0] iva0, ivb0;
  logic       rd1, ra1, rb1, cl1, st1, bz1, dn1;
  logic [6:0] ad1;
  logic [1:0] iva1;
  logic [3:0] ivb1;
  logic       rd2, ra2, rb2, cl2, st2, bz2, dn2;
  logic [6:0] ad2;
  logic [3:0] iva2, ivb2;

  systolic_seq_ctrl #(.WIDTH(4), .HEIGHT(4), .K_SIZE(16), .PE_LAT(1), .ADDR_W(7), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .read_data(rd0), .rd_en_A(ra0), .rd_en_B(rb0),
    .rd_addr(ad0), .clr_acc(cl0), .start_compute(st0), .in_valid_A(iva0), .in_valid_B(ivb0),
    .busy(bz0), .done(dn0));
  systolic_seq_ctrl #(.WIDTH(4), .HEIGHT(2), .K_SIZE(3), .PE_LAT(1), .ADDR_W(7), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .read_data(rd1), .rd_en_A(ra1), .rd_en_B(rb1),
    .rd_addr(ad1), .clr_acc(cl1), .start_compute(st1), .in_valid_A(iva1), .in_valid_B(ivb1),
    .busy(bz1), .done(dn1));
  systolic_seq_ctrl #(.WIDTH(4), .HEIGHT(4), .K_SIZE(16), .PE_LAT(3), .ADDR_W(7), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .read_data(rd2), .rd_en_A(ra2), .rd_en_B(rb2),
    .rd_addr(ad2), .clr_acc(cl2), .start_compute(st2), .in_valid_A(iva2), .in_valid_B(ivb2),
    .busy(bz2), .done(dn2));

  // {busy, done, read_data, rd_en_A, rd_en_B, clr_acc, start_compute, in_valid_A[3:0], in_valid_B[3:0], rd_addr}
  logic [21:0] obs0, obs1, obs2;
  assign obs0 = {bz0, dn0, rd0, ra0, rb0, cl0, st0, iva0, ivb0, ad0};
  assign obs1 = {bz1, dn1, rd1, ra1, rb1, cl1, st1, 2'b00, iva1, ivb1, ad1};
  assign obs2 = {bz2, dn2, rd2, ra2, rb2, cl2, st2, iva2, ivb2, ad2};

  function automatic int f_len(int i);
    int md;
    md = (PH[i] > PW[i]) ? PH[i] : PW[i];
    return PK[i] * md;
  endfunction

  function automatic int f_tend(int i);
    return PK[i] + PH[i] + PW[i] - 2 + PP[i];
  endfunction

  // Expected outputs k cycles after the accepting edge (k=1 is the first LOAD cycle).
  function automatic logic [21:0] exp_vec(int i, int k);
    logic [21:0] v;
    int l, te, a, t;
    l  = f_len(i);
    te = f_tend(i);
    v  = '0;
    if (k >= 1 && k <= l + te + 2) v[21] = 1'b1;
    if (k >= 1 && k <= l) begin
      a     = k - 1;
      v[18] = (a < PK[i] * PH[i]);
      v[17] = (a < PK[i] * PW[i]);
      v[19] = v[18] | v[17];
      v[16] = (k == 1);
      v[6:0] = 7'(a);
    end
    if (k >= l + 2 && k <= l + 1 + te) begin
      t     = k - l - 2;
      v[15] = (t == 0);
      for (int h = 0; h < PH[i]; h++) v[11 + h] = (t >= h) && (t < h + PK[i]);
      for (int w = 0; w < PW[i]; w++) v[7 + w] = (t >= w) && (t < w + PK[i]);
    end
    if (k == l + te + 2) v[20] = 1'b1;
    return v;
  endfunction

  logic [21:0] q0[$], q1[$], q2[$];
  int gq[$];
  int busy_left[3];
  int acc_cyc[3];
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  bit fin = 1'b0;

  int mem_a[64], mem_b[64];
  int a_buf[4][16], b_buf[4][16];
  int ia[4], ib[4];
  int a_p[4][4], b_p[4][4];
  bit a_v[4][4], b_v[4][4];
  int acc[4][4];

  task automatic push_exp(int i, logic [21:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete(); q1.delete(); q2.delete(); gq.delete();
      for (int i = 0; i < 3; i++) busy_left[i] = 0;
      for (int h = 0; h < 4; h++) begin
        ia[h] = 0; ib[h] = 0;
        for (int w = 0; w < 4; w++) begin
          a_v[h][w] = 1'b0; b_v[h][w] = 1'b0; acc[h][w] = 0;
        end
      end
      for (int n = 0; n < 64; n++) begin
        mem_a[n] = int'($urandom_range(0, 255));
        mem_b[n] = int'($urandom_range(0, 255));
      end
    end else begin
      cyc++;
      // Behavioural array driven by instance 0's current-cycle outputs.
      if (cl0) begin
        for (int h = 0; h < 4; h++) begin
          ia[h] = 0; ib[h] = 0;
          for (int w = 0; w < 4; w++) begin
            acc[h][w] = 0; a_v[h][w] = 1'b0; b_v[h][w] = 1'b0;
          end
        end
      end
      if (ra0 && ad0 < 7'd64) a_buf[int'(ad0) / 16][int'(ad0) % 16] = mem_a[int'(ad0)];
      if (rb0 && ad0 < 7'd64) b_buf[int'(ad0) / 16][int'(ad0) % 16] = mem_b[int'(ad0)];
      for (int h = 0; h < 4; h++) begin
        for (int w = 3; w > 0; w--) begin
          a_p[h][w] = a_p[h][w-1]; a_v[h][w] = a_v[h][w-1];
        end
        a_v[h][0] = iva0[h];
        if (iva0[h]) begin a_p[h][0] = a_buf[h][ia[h] % 16]; ia[h]++; end
      end
      for (int w = 0; w < 4; w++) begin
        for (int h = 3; h > 0; h--) begin
          b_p[h][w] = b_p[h-1][w]; b_v[h][w] = b_v[h-1][w];
        end
        b_v[0][w] = ivb0[w];
        if (ivb0[w]) begin b_p[0][w] = b_buf[w][ib[w] % 16]; ib[w]++; end
      end
      for (int h = 0; h < 4; h++)
        for (int w = 0; w < 4; w++)
          if (a_v[h][w] && b_v[h][w]) acc[h][w] += a_p[h][w] * b_p[h][w];
      // Acceptance model: a start is taken only when the previous run has fully retired.
      for (int i = 0; i < 3; i++) begin
        if (busy_left[i] > 0) begin
          busy_left[i]--;
          if (i == 0 && busy_left[0] == f_tend(0) + 1) begin
            for (int n = 0; n < 64; n++) begin
              mem_a[n] = int'($urandom_range(0, 255));
              mem_b[n] = int'($urandom_range(0, 255));
            end
          end
        end else if (data_valid) begin
          busy_left[i] = f_len(i) + f_tend(i) + 2;
          acc_cyc[i]   = cyc;
          for (int k = 1; k <= busy_left[i]; k++) push_exp(i, exp_vec(i, k));
          if (i == 0) begin
            for (int h = 0; h < 4; h++)
              for (int w = 0; w < 4; w++) begin
                int s;
                s = 0;
                for (int k = 0; k < 16; k++) s += mem_a[h*16 + k] * mem_b[w*16 + k];
                gq.push_back(s);
              end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [21:0] o, e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin o = obs0; e = (q0.size() > 0) ? q0.pop_front() : 22'd0; end
        1: begin o = obs1; e = (q1.size() > 0) ? q1.pop_front() : 22'd0; end
        default: begin o = obs2; e = (q2.size() > 0) ? q2.pop_front() : 22'd0; end
      endcase
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL trace inst%0d cyc%0d: got %h, want %h", i, cyc, o, e);
      end
      if (o[20] === 1'b1) begin
        compared++;
        if (cyc - acc_cyc[i] != f_len(i) + 1 + f_tend(i)) begin
          mismatched++;
          $display("FAIL latency inst%0d: got %0d edges, want %0d", i, cyc - acc_cyc[i], f_len(i) + 1 + f_tend(i));
        end
        if (i == 0) begin
          for (int n = 0; n < 16; n++) begin
            int g;
            g = (gq.size() > 0) ? gq.pop_front() : -1;
            compared++;
            if (acc[n / 4][n % 4] != g) begin
              mismatched++;
              $display("FAIL result C[%0d][%0d]: got %0d, want %0d", n / 4, n % 4, acc[n / 4][n % 4], g);
            end
          end
        end
      end
    end
    if (fin) begin
      compared++;
      if (q0.size() + q1.size() + q2.size() + gq.size() != 0) begin
        mismatched++;
        $display("FAIL drain: got %0d pending, want 0", q0.size() + q1.size() + q2.size() + gq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  end

  task automatic pulse_start();
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // Single run.
    pulse_start();
    repeat (100) @(negedge clk);
    // Requests during COMPUTE t=5 and during DONE of instance 0 must be ignored.
    pulse_start();
    repeat (70) @(negedge clk);
    pulse_start();
    repeat (17) @(negedge clk);
    pulse_start();
    repeat (100) @(negedge clk);
    // Request held high: back-to-back runs.
    data_valid = 1'b1;
    repeat (200) @(negedge clk);
    data_valid = 1'b0;
    repeat (100) @(negedge clk);
    // Abort at COMPUTE t=10 of instance 0, then a clean run.
    pulse_start();
    repeat (74) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (100) @(negedge clk);
    // Random request traffic.
    repeat (300) begin
      data_valid = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    data_valid = 1'b0;
    repeat (110) @(negedge clk);
    fin = 1'b1;
  end

endmodule
